// File: rtl/inst_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: FSM state codes,
// opcode/funct constants, ALU operation codes and decoded instruction classes.
package inst_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [2:0] {
    C_ILL, C_RTYPE, C_IMM, C_LW, C_SW, C_BEQ, C_BNE, C_J
  } iclass_t;

endpackage

// File: rtl/inst_ctrl_decode.sv
// Combinational instruction decode: opcode/funct -> class, ALU op,
// destination select (rt vs rd) and immediate extension mode.
module inst_decode
  import inst_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output iclass_t    cls,
    output logic [2:0] alu_op,
    output logic       wr_rt,
    output logic       zext
);

    always_comb begin
        cls    = C_ILL;
        alu_op = ALU_AND;
        wr_rt  = 1'b0;
        zext   = 1'b0;
        case (op)
            OP_RTYPE: begin
                cls = C_RTYPE;
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: cls = C_ILL;
                endcase
            end
            OP_ADDI: begin cls = C_IMM; alu_op = ALU_ADD; wr_rt = 1'b1; end
            OP_ANDI: begin cls = C_IMM; alu_op = ALU_AND; wr_rt = 1'b1; zext = 1'b1; end
            OP_ORI:  begin cls = C_IMM; alu_op = ALU_OR;  wr_rt = 1'b1; zext = 1'b1; end
            OP_XORI: begin cls = C_IMM; alu_op = ALU_XOR; wr_rt = 1'b1; zext = 1'b1; end
            OP_LW:   begin cls = C_LW;  alu_op = ALU_ADD; wr_rt = 1'b1; end
            OP_SW:   begin cls = C_SW;  alu_op = ALU_ADD; wr_rt = 1'b1; end
            OP_BEQ:  begin cls = C_BEQ; alu_op = ALU_SUB; end
            OP_BNE:  begin cls = C_BNE; alu_op = ALU_SUB; end
            OP_J:    cls = C_J;
            default: cls = C_ILL;
        endcase
    end

endmodule

// File: rtl/inst_ctrl.sv
// Multi-cycle Moore control FSM: owns the IR, sequences IF/ID/EX/MEM/WB and
// decodes strobes from state + IR (zero only qualifies the branch strobe).
module inst_ctrl
  import inst_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Inst_code,
    input  logic        zero,
    output logic [2:0]  state,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic [1:0]  pc_src,
    output logic        ir_write,
    output logic        reg_write,
    output logic        mem_write,
    output logic [2:0]  ALU_OP,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    output logic [4:0]  wr_addr,
    output logic [31:0] imm_ext,
    output logic        illegal
);

    state_t      cur, nxt;
    logic [31:0] ir;
    iclass_t     cls;
    logic [2:0]  dec_alu;
    logic        wr_rt, zext;
    logic        unused_shamt;

    inst_decode u_dec (
        .op     (ir[31:26]),
        .funct  (ir[5:0]),
        .cls    (cls),
        .alu_op (dec_alu),
        .wr_rt  (wr_rt),
        .zext   (zext)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            cur <= S_IDLE;
            ir  <= '0;
        end else begin
            cur <= nxt;
            if (cur == S_IF) ir <= Inst_code;
        end
    end

    always_comb begin
        nxt = cur;
        case (cur)
            S_IDLE: nxt = S_IF;
            S_IF:   nxt = S_ID;
            S_ID:   nxt = (cls == C_J || cls == C_ILL) ? S_IF : S_EX;
            S_EX: begin
                if (cls == C_BEQ || cls == C_BNE)     nxt = S_IF;
                else if (cls == C_LW || cls == C_SW)  nxt = S_MEM;
                else                                  nxt = S_WB;
            end
            S_MEM:  nxt = (cls == C_LW) ? S_WB : S_IF;
            S_WB:   nxt = S_IF;
            default: nxt = S_IDLE;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 2'b00;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        mem_write     = 1'b0;
        ALU_OP        = ALU_AND;
        illegal       = 1'b0;
        case (cur)
            S_IF: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
            end
            S_ID: begin
                if (cls == C_J) begin
                    pc_write = 1'b1;
                    pc_src   = 2'b10;
                end
                illegal = (cls == C_ILL);
            end
            S_EX: begin
                ALU_OP = dec_alu;
                if (cls == C_BEQ || cls == C_BNE) begin
                    pc_src        = 2'b01;
                    pc_write_cond = (cls == C_BEQ) ? zero : ~zero;
                end
            end
            S_MEM:   mem_write = (cls == C_SW);
            S_WB:    reg_write = 1'b1;
            default: ;
        endcase
    end

    assign state        = cur;
    assign rs_addr      = ir[25:21];
    assign rt_addr      = ir[20:16];
    assign wr_addr      = wr_rt ? ir[20:16] : ir[15:11];
    assign imm_ext      = zext ? {16'h0000, ir[15:0]} : {{16{ir[15]}}, ir[15:0]};
    assign unused_shamt = ^ir[10:6];

endmodule
